// File: rtl/bram_chunk_drain_if.sv
// bram_chunk_drain_if
//    AXI4-Stream bundle carrying one packed D2Q9 cell per beat.
//    master modport: drives tdata, tvalid, tlast, tkeep; samples tready.
//    slave  modport: the mirror image, for whatever consumes the stream.
//    DATA_W is the width of one direction word; a beat holds nine of them.
interface bram_chunk_drain_if #(
   parameter int DATA_W = 16
);
   logic [9*DATA_W-1:0]   tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [9*DATA_W/8-1:0] tkeep;

   modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/bram_chunk_drain.sv
// bram_chunk_drain
//    Reads the nine D2Q9 direction banks at a shared address, packs each cell
//    into one AXI4-Stream beat and streams the chunk out toward DDR.
//    m00_axis_aclk / m00_axis_aresetn : clock, asynchronous active-low reset
//    start, cell_count                : one-cycle kick-off and number of cells
//    drain_active, done               : BRAM port ownership flag, completion pulse
//    rd_addr, rd_en                   : shared read port to all nine banks
//    null_q .. nw_q                   : bank read data, BRAM_LAT cycles after rd_en
//    m00_axis                         : outbound stream, {nw,w,sw,s,se,e,ne,n,null}
module bram_chunk_drain #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int BRAM_LAT   = 1
) (
   input  logic              m00_axis_aclk,
   input  logic              m00_axis_aresetn,
   input  logic              start,
   input  logic [ADDR_W:0]   cell_count,
   output logic              drain_active,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [DATA_W-1:0] null_q,
   input  logic [DATA_W-1:0] n_q,
   input  logic [DATA_W-1:0] ne_q,
   input  logic [DATA_W-1:0] e_q,
   input  logic [DATA_W-1:0] se_q,
   input  logic [DATA_W-1:0] s_q,
   input  logic [DATA_W-1:0] sw_q,
   input  logic [DATA_W-1:0] w_q,
   input  logic [DATA_W-1:0] nw_q,
   bram_chunk_drain_if.master m00_axis
);

   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int CW     = $clog2(FIFO_DEPTH + BRAM_LAT + 1) + 1;
   localparam int BEAT_W = 9 * DATA_W;

   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [PW:0]     PTR_ONE = {{PW{1'b0}}, 1'b1};
   localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t              state;
   state_t              stateNext;
   logic [ADDR_W:0]     countQ;
   logic [ADDR_W:0]     addrCnt;
   logic [ADDR_W:0]     sentCnt;
   logic [BRAM_LAT-1:0] inflightVld;
   logic [BEAT_W-1:0]   fifoMem [FIFO_DEPTH];
   logic [PW:0]         wrPtr;
   logic [PW:0]         rdPtr;

   logic [PW:0]         occupancy;
   logic [CW-1:0]       inflight;
   logic                fifoEmpty;
   logic                push;
   logic                pop;
   logic                creditOk;
   logic                lastAddr;
   logic                lastBeat;
   logic                allSent;
   logic                drained;
   logic                accept;
   logic [BEAT_W-1:0]   pushData;

   // Count the reads still travelling through the BRAM pipeline.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < BRAM_LAT; i++)
         inflight = inflight + {{(CW-1){1'b0}}, inflightVld[i]};
   end

   // Credit: a read may only be issued if its data is guaranteed a FIFO slot,
   // so the FIFO can never overflow regardless of backpressure.
   always_comb begin
      occupancy = wrPtr - rdPtr;
      fifoEmpty = (occupancy == '0);
      push      = inflightVld[BRAM_LAT-1];
      pop       = !fifoEmpty && m00_axis.tready;
      creditOk  = (CW'(occupancy) + inflight) < DEPTH_C;
      lastAddr  = (addrCnt == countQ - CNT_ONE);
      lastBeat  = (sentCnt == countQ - CNT_ONE);
      allSent   = (sentCnt == countQ) || (pop && lastBeat);
      drained   = fifoEmpty || (pop && occupancy == PTR_ONE);
      accept    = (state == IDLE) && start;
      pushData  = {nw_q, w_q, sw_q, s_q, se_q, e_q, ne_q, n_q, null_q};
   end

   // Next-state and control outputs. A zero-cell drain goes through one
   // FLUSH cycle (which exits at once) so the BRAM ports are still claimed
   // for a cycle and done lands two cycles after start.
   always_comb begin
      stateNext    = state;
      rd_en        = 1'b0;
      done         = 1'b0;
      drain_active = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               stateNext = (cell_count == '0) ? FLUSH : RUN;
         end
         RUN: begin
            drain_active = 1'b1;
            if (creditOk) begin
               rd_en = 1'b1;
               if (lastAddr)
                  stateNext = FLUSH;
            end
         end
         FLUSH: begin
            drain_active = 1'b1;
            if (inflight == '0 && drained && allSent)
               stateNext = DONE;
         end
         DONE: begin
            done      = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
      if (!m00_axis_aresetn)
         state <= IDLE;
      else
         state <= stateNext;
   end

   // Cell count, read address counter, beat counter and read-latency pipe.
   always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
      if (!m00_axis_aresetn) begin
         countQ      <= '0;
         addrCnt     <= '0;
         sentCnt     <= '0;
         inflightVld <= '0;
      end else begin
         if (accept) begin
            countQ  <= cell_count;
            addrCnt <= '0;
            sentCnt <= '0;
         end else begin
            if (rd_en)
               addrCnt <= addrCnt + CNT_ONE;
            if (pop)
               sentCnt <= sentCnt + CNT_ONE;
         end
         inflightVld[0] <= rd_en;
         for (int i = 1; i < BRAM_LAT; i++)
            inflightVld[i] <= inflightVld[i-1];
      end
   end

   // Output FIFO: data is captured the cycle it leaves the BRAM pipe.
   always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
      if (!m00_axis_aresetn) begin
         wrPtr <= '0;
         rdPtr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            fifoMem[i] <= '0;
      end else begin
         if (push) begin
            fifoMem[wrPtr[PW-1:0]] <= pushData;
            wrPtr                  <= wrPtr + PTR_ONE;
         end
         if (pop)
            rdPtr <= rdPtr + PTR_ONE;
      end
   end

   assign rd_addr         = addrCnt[ADDR_W-1:0];
   assign m00_axis.tvalid = !fifoEmpty;
   assign m00_axis.tdata  = fifoMem[rdPtr[PW-1:0]];
   assign m00_axis.tlast  = !fifoEmpty && lastBeat;
   assign m00_axis.tkeep  = '1;

endmodule

// File: tb/tb_bram_chunk_drain.sv
`timescale 1ns/1ps
module tb_bram_chunk_drain;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;
   localparam int BW     = 9 * DATA_W;

   logic              clk = 1'b0;
   logic              aresetn = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   cell_count = '0;
   logic              drain_active;
   logic              done;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] bank_q [9];

   int bank_base = 0;
   int cyc = 0;
   int checks = 0;
   int failures = 0;

   bram_chunk_drain_if #(.DATA_W(DATA_W)) axis ();

   bram_chunk_drain #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .BRAM_LAT(1)) dut (
      .m00_axis_aclk(clk), .m00_axis_aresetn(aresetn), .start(start), .cell_count(cell_count),
      .drain_active(drain_active), .done(done), .rd_addr(rd_addr), .rd_en(rd_en),
      .null_q(bank_q[0]), .n_q(bank_q[1]), .ne_q(bank_q[2]), .e_q(bank_q[3]), .se_q(bank_q[4]),
      .s_q(bank_q[5]), .sw_q(bank_q[6]), .w_q(bank_q[7]), .nw_q(bank_q[8]),
      .m00_axis(axis)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bank model: direction k at address a holds base + a + k, one-cycle read latency.
   always @(posedge clk)
      if (rd_en)
         for (int k = 0; k < 9; k++)
            bank_q[k] <= DATA_W'(bank_base + int'(rd_addr) + k);

   // Expected packed cell for beat idx: lane k carries base + idx + k.
   function automatic logic [BW-1:0] exp_beat(input int base, input int idx);
      logic [BW-1:0] r;
      r = '0;
      for (int k = 0; k < 9; k++)
         r[k*DATA_W +: DATA_W] = DATA_W'(base + idx + k);
      return r;
   endfunction

   // Observations of one drain.
   logic [BW-1:0] beat_data [$];
   int            beat_cyc [$];
   bit            beat_last [$];
   int            rd_addr_q [$];
   int            rd_cyc_q [$];
   int t0, done_cyc, active_cnt, active_first, active_last, valid_cnt, stall_err, max_out, timeout;

   // Pulse start with n cells and watch the bus until done. mode: 0 ready high,
   // 1 ready pattern 1-0-0-1, 2 random ready. A second start is pulsed at
   // offset restart_off (0 = never) with restart_n cells.
   task automatic applyStimulus(input int n, input int mode, input int restart_off, input int restart_n);
      int budget, reads, accepts, outstanding;
      bit p_valid, p_ready, p_last, got_done;
      logic [BW-1:0] p_data;
      beat_data.delete(); beat_cyc.delete(); beat_last.delete();
      rd_addr_q.delete(); rd_cyc_q.delete();
      done_cyc = -1; active_cnt = 0; active_first = -1; active_last = -1;
      valid_cnt = 0; stall_err = 0; max_out = 0; timeout = 0;
      reads = 0; accepts = 0; p_valid = 0; p_ready = 0; p_last = 0; p_data = '0; got_done = 0;
      budget = 4 * n + 60;
      @(negedge clk);
      start = 1'b1; cell_count = (ADDR_W+1)'(n); axis.tready = 1'b1; t0 = cyc;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         start = (i == restart_off);
         cell_count = (i == restart_off) ? (ADDR_W+1)'(restart_n) : (ADDR_W+1)'(n);
         case (mode)
            0: axis.tready = 1'b1;
            1: axis.tready = (((i-1) % 4) == 0) || (((i-1) % 4) == 3);
            default: axis.tready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (rd_en) begin
            outstanding = reads - accepts;
            if (outstanding + 1 > max_out) max_out = outstanding + 1;
            rd_addr_q.push_back(int'(rd_addr)); rd_cyc_q.push_back(cyc); reads++;
         end
         if (drain_active) begin
            if (active_cnt == 0) active_first = cyc;
            active_last = cyc; active_cnt++;
         end
         if (axis.tvalid) valid_cnt++;
         if (p_valid && !p_ready)
            if (!axis.tvalid || axis.tdata !== p_data || axis.tlast !== p_last) stall_err++;
         if (axis.tvalid && axis.tready) begin
            beat_data.push_back(axis.tdata); beat_cyc.push_back(cyc); beat_last.push_back(axis.tlast);
            accepts++;
         end
         p_valid = axis.tvalid; p_ready = axis.tready; p_data = axis.tdata; p_last = axis.tlast;
         if (done) begin
            done_cyc = cyc; got_done = 1;
            break;
         end
      end
      start = 1'b0;
      if (!got_done) timeout = 1;
   endtask

   task automatic test_reset();
      aresetn = 1'b0; axis.tready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (rd_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_en got=%0b exp=0", rd_en); end
      checks++; if (rd_addr !== '0) begin failures++; $display("[TB] FAIL reset_rd_addr got=%0h exp=0", rd_addr); end
      checks++; if (drain_active !== 1'b0) begin failures++; $display("[TB] FAIL reset_active got=%0b exp=0", drain_active); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
      checks++; if (axis.tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tvalid got=%0b exp=0", axis.tvalid); end
      checks++; if (axis.tlast !== 1'b0) begin failures++; $display("[TB] FAIL reset_tlast got=%0b exp=0", axis.tlast); end
      checks++; if (axis.tdata !== '0) begin failures++; $display("[TB] FAIL reset_tdata got=%0h exp=0", axis.tdata); end
      checks++; if (axis.tkeep !== {(BW/8){1'b1}}) begin failures++; $display("[TB] FAIL reset_tkeep got=%0h exp=3ffff", axis.tkeep); end
      @(negedge clk); aresetn = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (drain_active !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("[TB] FAIL idle_quiet got=%0b%0b exp=00", drain_active, rd_en); end
   endtask

   task automatic test_basic();
      int n;
      n = 8; bank_base = 0;
      applyStimulus(n, 0, 0, 0);
      checks++; if (timeout !== 0) begin failures++; $display("[TB] FAIL basic_timeout got=%0d exp=0", timeout); end
      checks++; if (beat_data.size() !== n) begin failures++; $display("[TB] FAIL basic_beats got=%0d exp=%0d", beat_data.size(), n); end
      checks++; if (rd_addr_q.size() !== n) begin failures++; $display("[TB] FAIL basic_reads got=%0d exp=%0d", rd_addr_q.size(), n); end
      for (int i = 0; i < beat_data.size() && i < n; i++) begin
         checks++; if (beat_data[i] !== exp_beat(bank_base, i)) begin failures++; $display("[TB] FAIL basic_data[%0d] got=%0h exp=%0h", i, beat_data[i], exp_beat(bank_base, i)); end
         checks++; if (beat_cyc[i] !== t0 + 3 + i) begin failures++; $display("[TB] FAIL basic_beat_cyc[%0d] got=%0d exp=%0d", i, beat_cyc[i] - t0, 3 + i); end
         checks++; if (beat_last[i] !== bit'(i == n - 1)) begin failures++; $display("[TB] FAIL basic_tlast[%0d] got=%0b exp=%0b", i, beat_last[i], i == n - 1); end
      end
      for (int i = 0; i < rd_addr_q.size() && i < n; i++) begin
         checks++; if (rd_addr_q[i] !== i || rd_cyc_q[i] !== t0 + 1 + i) begin failures++; $display("[TB] FAIL basic_read[%0d] got=addr %0d cyc %0d exp=addr %0d cyc %0d", i, rd_addr_q[i], rd_cyc_q[i] - t0, i, 1 + i); end
      end
      checks++; if (done_cyc !== t0 + n + 3) begin failures++; $display("[TB] FAIL basic_done_cyc got=%0d exp=%0d", done_cyc - t0, n + 3); end
      checks++; if (active_first !== t0 + 1 || active_last !== t0 + n + 2 || active_cnt !== n + 2) begin failures++; $display("[TB] FAIL basic_active got=%0d..%0d exp=1..%0d", active_first - t0, active_last - t0, n + 2); end
      @(negedge clk); #1;
      checks++; if (done !== 1'b0 || drain_active !== 1'b0) begin failures++; $display("[TB] FAIL basic_after_done got=%0b%0b exp=00", done, drain_active); end
   endtask

   task automatic test_backpressure();
      int n, lasts;
      n = 16; bank_base = 100;
      applyStimulus(n, 1, 0, 0);
      lasts = 0;
      foreach (beat_last[i]) lasts += beat_last[i];
      checks++; if (timeout !== 0) begin failures++; $display("[TB] FAIL bp_timeout got=%0d exp=0", timeout); end
      checks++; if (beat_data.size() !== n) begin failures++; $display("[TB] FAIL bp_beats got=%0d exp=%0d", beat_data.size(), n); end
      for (int i = 0; i < beat_data.size() && i < n; i++) begin
         checks++; if (beat_data[i] !== exp_beat(bank_base, i)) begin failures++; $display("[TB] FAIL bp_data[%0d] got=%0h exp=%0h", i, beat_data[i], exp_beat(bank_base, i)); end
      end
      checks++; if (stall_err !== 0) begin failures++; $display("[TB] FAIL bp_stable got=%0d exp=0", stall_err); end
      checks++; if (max_out > 4) begin failures++; $display("[TB] FAIL bp_credit got=%0d exp<=4", max_out); end
      checks++; if (lasts !== 1 || (beat_last.size() == n && beat_last[n-1] !== 1'b1)) begin failures++; $display("[TB] FAIL bp_tlast got=%0d exp=1", lasts); end
   endtask

   task automatic test_zero();
      applyStimulus(0, 0, 0, 0);
      checks++; if (timeout !== 0) begin failures++; $display("[TB] FAIL zero_timeout got=%0d exp=0", timeout); end
      checks++; if (rd_addr_q.size() !== 0) begin failures++; $display("[TB] FAIL zero_reads got=%0d exp=0", rd_addr_q.size()); end
      checks++; if (valid_cnt !== 0) begin failures++; $display("[TB] FAIL zero_tvalid got=%0d exp=0", valid_cnt); end
      checks++; if (done_cyc !== t0 + 2) begin failures++; $display("[TB] FAIL zero_done_cyc got=%0d exp=2", done_cyc - t0); end
      checks++; if (active_cnt !== 1 || active_first !== t0 + 1) begin failures++; $display("[TB] FAIL zero_active got=%0d@%0d exp=1@1", active_cnt, active_first - t0); end
   endtask

   task automatic test_full();
      int n, dups, bad;
      bit seen [4096];
      n = 4096; bank_base = 7; dups = 0; bad = 0;
      applyStimulus(n, 2, 0, 0);
      foreach (rd_addr_q[i]) begin
         if (seen[rd_addr_q[i]]) dups++;
         seen[rd_addr_q[i]] = 1'b1;
      end
      checks++; if (timeout !== 0) begin failures++; $display("[TB] FAIL full_timeout got=%0d exp=0", timeout); end
      checks++; if (rd_addr_q.size() !== n || dups !== 0) begin failures++; $display("[TB] FAIL full_reads got=%0d dups=%0d exp=%0d dups=0", rd_addr_q.size(), dups, n); end
      checks++; if (rd_addr_q.size() == 0 || rd_addr_q[rd_addr_q.size()-1] !== 12'hFFF) begin failures++; $display("[TB] FAIL full_last_addr got=%0h exp=fff", rd_addr_q.size() ? rd_addr_q[rd_addr_q.size()-1] : -1); end
      checks++; if (beat_data.size() !== n) begin failures++; $display("[TB] FAIL full_beats got=%0d exp=%0d", beat_data.size(), n); end
      for (int i = 0; i < beat_data.size() && i < n; i++)
         if (beat_data[i] !== exp_beat(bank_base, i) || beat_last[i] !== bit'(i == n - 1)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL full_data got=%0d bad beats exp=0", bad); end
      checks++; if (stall_err !== 0 || max_out > 4) begin failures++; $display("[TB] FAIL full_flow got=stall %0d credit %0d exp=stall 0 credit<=4", stall_err, max_out); end
   endtask

   task automatic test_second_start();
      int n;
      n = 10; bank_base = 300;
      applyStimulus(n, 0, 4, 20);
      checks++; if (timeout !== 0) begin failures++; $display("[TB] FAIL restart_timeout got=%0d exp=0", timeout); end
      checks++; if (beat_data.size() !== n) begin failures++; $display("[TB] FAIL restart_beats got=%0d exp=%0d", beat_data.size(), n); end
      checks++; if (done_cyc !== t0 + n + 3) begin failures++; $display("[TB] FAIL restart_done_cyc got=%0d exp=%0d", done_cyc - t0, n + 3); end
      repeat (3) @(negedge clk);
      #1;
      checks++; if (drain_active !== 1'b0) begin failures++; $display("[TB] FAIL restart_idle got=%0b exp=0", drain_active); end
   endtask

   task automatic test_reset_mid();
      bank_base = 500;
      @(negedge clk);
      start = 1'b1; cell_count = (ADDR_W+1)'(16); axis.tready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      checks++; if (axis.tvalid !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_valid got=%0b exp=1", axis.tvalid); end
      #1 aresetn = 1'b0;
      #1;
      checks++; if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0 || axis.tdata !== '0) begin failures++; $display("[TB] FAIL mid_stream_zero got=v%0b l%0b d%0h exp=0", axis.tvalid, axis.tlast, axis.tdata); end
      checks++; if (rd_en !== 1'b0 || rd_addr !== '0 || drain_active !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL mid_ctrl_zero got=%0b %0h %0b %0b exp=0", rd_en, rd_addr, drain_active, done); end
      @(negedge clk); aresetn = 1'b1;
      bank_base = 900;
      applyStimulus(2, 0, 0, 0);
      checks++; if (timeout !== 0 || beat_data.size() !== 2) begin failures++; $display("[TB] FAIL mid_fresh_beats got=%0d exp=2", beat_data.size()); end
      for (int i = 0; i < beat_data.size() && i < 2; i++) begin
         checks++; if (beat_data[i] !== exp_beat(bank_base, i) || beat_last[i] !== bit'(i == 1)) begin failures++; $display("[TB] FAIL mid_fresh[%0d] got=%0h exp=%0h", i, beat_data[i], exp_beat(bank_base, i)); end
      end
   endtask

   task automatic test_random();
      int n, bad;
      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(1, 40); bank_base = $urandom_range(0, 65535); bad = 0;
         applyStimulus(n, 2, 0, 0);
         for (int i = 0; i < beat_data.size() && i < n; i++)
            if (beat_data[i] !== exp_beat(bank_base, i) || beat_last[i] !== bit'(i == n - 1)) bad++;
         checks++; if (timeout !== 0 || beat_data.size() !== n) begin failures++; $display("[TB] FAIL rand%0d_beats got=%0d exp=%0d", r, beat_data.size(), n); end
         checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL rand%0d_data got=%0d bad exp=0", r, bad); end
         checks++; if (stall_err !== 0 || max_out > 4) begin failures++; $display("[TB] FAIL rand%0d_flow got=stall %0d credit %0d exp=0,<=4", r, stall_err, max_out); end
      end
   endtask

   // Scenario sequence.
   initial begin
      axis.tready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_zero();
      test_second_start();
      test_reset_mid();
      test_random();
      test_full();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
